// File: rtl/ads8689_pkg.sv
// ----------------------------------------------------------------------------
// ads8689_pkg
// Shared definitions for one ADS8689 channel: sequencer state encodings (also
// decoded by the register-command generator), frame indices, timing constants
// and the ADS8689 command / register address constants.
// ----------------------------------------------------------------------------
package ads8689_pkg;

  // Sequencer states: one-hot except IDLE. The register-command generator
  // decodes CON_RDY and RD_RDY, so these values must stay in sync with it.
  localparam logic [7:0] ST_IDLE     = 8'h00;
  localparam logic [7:0] ST_CON_RDY  = 8'h01;
  localparam logic [7:0] ST_CON_WAIT = 8'h02;
  localparam logic [7:0] ST_CON_GAP  = 8'h04;
  localparam logic [7:0] ST_CNV_HI   = 8'h08;
  localparam logic [7:0] ST_CNV_WAIT = 8'h10;
  localparam logic [7:0] ST_RD_RDY   = 8'h20;
  localparam logic [7:0] ST_RD_WAIT  = 8'h40;
  localparam logic [7:0] ST_FAULT    = 8'h80;

  // Frame index that selects the data-read frame.
  localparam logic [4:0]  CON_CNT = 5'd16;
  // Number of configuration frames (wr_cnt 0..CFG_FRM-1).
  localparam logic [3:0]  CFG_FRM = 4'd8;
  // CONVST high time, 1 us at 125 MHz.
  localparam logic [15:0] CNV_CYC = 16'd125;
  // Idle cycles between configuration frames.
  localparam logic [7:0]  GAP_CYC = 8'd8;
  // Sample period in clock cycles.
  localparam logic [15:0] SMP_PRD = 16'd1250;
  // Watchdog limit for SPI done / RVS waits.
  localparam logic [15:0] TMO_CYC = 16'd4095;

  // ADS8689 SPI command opcodes (upper bits of the 32-bit command word).
  localparam logic [7:0] CMD_NOP       = 8'h00;
  localparam logic [7:0] CMD_CLEAR_HW  = 8'hC0;
  localparam logic [7:0] CMD_READ_HW   = 8'hC8;
  localparam logic [7:0] CMD_READ      = 8'h48;
  localparam logic [7:0] CMD_WRITE     = 8'hD0;
  localparam logic [7:0] CMD_WRITE_MSB = 8'hD2;
  localparam logic [7:0] CMD_WRITE_LSB = 8'hD4;
  localparam logic [7:0] CMD_SET_HW    = 8'hD8;

  // ADS8689 register addresses.
  localparam logic [8:0] REG_DEVICE_ID   = 9'h000;
  localparam logic [8:0] REG_RST_PWRCTL  = 9'h004;
  localparam logic [8:0] REG_SDI_CTL     = 9'h008;
  localparam logic [8:0] REG_SDO_CTL     = 9'h00C;
  localparam logic [8:0] REG_DATAOUT_CTL = 9'h010;
  localparam logic [8:0] REG_RANGE_SEL   = 9'h014;
  localparam logic [8:0] REG_ALARM       = 9'h020;
  localparam logic [8:0] REG_ALARM_H_TH  = 9'h024;
  localparam logic [8:0] REG_ALARM_L_TH  = 9'h028;

  // States in which the sequencer waits on an external event.
  function automatic logic is_wait_state(input logic [7:0] st);
    return (st == ST_CON_WAIT) || (st == ST_CNV_WAIT) || (st == ST_RD_WAIT);
  endfunction

endpackage

// File: rtl/ads8689_dncnt.sv
// ----------------------------------------------------------------------------
// ads8689_dncnt
// Loadable down-counter with zero flag. Load has priority over decrement;
// decrement saturates at zero.
// Ports:
//   clk        - clock
//   rst_n      - asynchronous active-low reset (count clears to 0)
//   load_i     - load load_val_i on the next edge
//   load_val_i - value to load
//   dec_i      - decrement by one (ignored when already zero)
//   zero_o     - count is zero
// ----------------------------------------------------------------------------
module ads8689_dncnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ads8689_seq.sv
// ----------------------------------------------------------------------------
// ads8689_seq
// Sequencer for one ADS8689 channel. After ad_en rises it walks the eight
// configuration frames, then runs periodic CONVST -> RVS -> read cycles and
// presents each 16-bit sample with a one-cycle strobe.
//
// Build option: define ADS8689_TMO_EN to enable the watchdog on the
// CON_WAIT / CNV_WAIT / RD_WAIT states (expiry -> FAULT). Without it those
// states wait indefinitely and ad_fault is tied low.
//
// Ports:
//   clk_sys    - system clock (125 MHz)
//   rst_sys_n  - asynchronous active-low reset
//   ad_en      - channel enable (level)
//   spi_done   - SPI frame complete pulse
//   spi_rdata  - SPI frame read data, valid with spi_done
//   ad_rvs     - ADS8689 RVS (already synchronised), high = conversion done
//   cur_state  - sequencer state to the register-command generator
//   wr_cnt     - frame index to the register-command generator
//   ad_convst  - CONVST pin
//   ad_data    - last sample (spi_rdata[31:16])
//   ad_vld     - one-cycle strobe with new ad_data
//   cfg_done   - configuration burst completed
//   smp_ovr    - sticky: period tick arrived while a cycle was in progress
//   ad_fault   - sticky: watchdog expired
// ----------------------------------------------------------------------------
module ads8689_seq
  import ads8689_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        ad_en,
  input  logic        spi_done,
  input  logic [31:0] spi_rdata,
  input  logic        ad_rvs,
  output logic [7:0]  cur_state,
  output logic [4:0]  wr_cnt,
  output logic        ad_convst,
  output logic [15:0] ad_data,
  output logic        ad_vld,
  output logic        cfg_done,
  output logic        smp_ovr,
  output logic        ad_fault
);

  logic [7:0]  state_q, state_d;
  logic [4:0]  wr_cnt_q, wr_cnt_d;
  logic        convst_q;
  logic [15:0] ad_data_q, ad_data_d;
  logic        ad_vld_q, ad_vld_d;
  logic        cfg_done_q, cfg_done_d;
  logic        smp_ovr_q, smp_ovr_d;
  logic        ad_en_q;
  logic [15:0] prd_q, prd_d;

  logic        en_rise;
  logic        prd_run;
  logic        prd_tick;
  logic        tmr_load;
  logic [15:0] tmr_load_val;
  logic        tmr_dec;
  logic        tmr_zero;
  logic        tmo;
  logic [4:0]  wr_cnt_inc;

  // Lower half of the read frame carries no sample data.
  logic        unused_rdata_lo;
  assign unused_rdata_lo = ^spi_rdata[15:0];

  assign en_rise    = ad_en && !ad_en_q;
  assign wr_cnt_inc = wr_cnt_q + 5'd1;

  // --------------------------------------------------------------------------
  // Sample period counter: free-runs only once configured and enabled, so the
  // first tick lands a full period after cfg_done rises or ad_en re-asserts.
  // --------------------------------------------------------------------------
  assign prd_run  = cfg_done_q && ad_en;
  assign prd_tick = prd_run && (prd_q == SMP_PRD - 16'd1);

  always_comb begin
    prd_d = 16'd0;
    if (prd_run && !prd_tick) begin
      prd_d = prd_q + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Shared gap / CONVST timer. Loaded with N-1 on entry so the state lasts
  // exactly N cycles (exit on the cycle the count reads zero).
  // --------------------------------------------------------------------------
  assign tmr_load = (state_d != state_q) &&
                    ((state_d == ST_CON_GAP) || (state_d == ST_CNV_HI));
  assign tmr_load_val = (state_d == ST_CNV_HI) ? (CNV_CYC - 16'd1)
                                               : {8'd0, GAP_CYC - 8'd1};
  assign tmr_dec  = (state_q == ST_CON_GAP) || (state_q == ST_CNV_HI);

  ads8689_dncnt #(
    .W (16)
  ) u_tmr (
    .clk        (clk_sys),
    .rst_n      (rst_sys_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

`ifdef ADS8689_TMO_EN
  // --------------------------------------------------------------------------
  // Watchdog: reloaded on every state change, counts down while waiting on an
  // external event. Expiry is raised on the TMO_CYC-th cycle in the state.
  // --------------------------------------------------------------------------
  logic wd_zero;
  logic fault_q;

  ads8689_dncnt #(
    .W (16)
  ) u_wd (
    .clk        (clk_sys),
    .rst_n      (rst_sys_n),
    .load_i     (state_d != state_q),
    .load_val_i (TMO_CYC - 16'd1),
    .dec_i      (is_wait_state(state_q)),
    .zero_o     (wd_zero)
  );

  assign tmo = is_wait_state(state_q) && wd_zero;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      fault_q <= 1'b0;
    end else if (en_rise) begin
      fault_q <= 1'b0;
    end else if (state_d == ST_FAULT) begin
      fault_q <= 1'b1;
    end
  end

  assign ad_fault = fault_q;
`else
  assign tmo      = 1'b0;
  assign ad_fault = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Sequencer next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    cfg_done_d = cfg_done_q;
    ad_data_d  = ad_data_q;
    ad_vld_d   = 1'b0;
    smp_ovr_d  = smp_ovr_q;

    case (state_q)
      ST_IDLE: begin
        if (ad_en && !cfg_done_q) begin
          state_d  = ST_CON_RDY;
          wr_cnt_d = 5'd0;
        end else if (ad_en && cfg_done_q && prd_tick) begin
          state_d = ST_CNV_HI;
        end
      end

      ST_CON_RDY: begin
        state_d = ST_CON_WAIT;
      end

      ST_CON_WAIT: begin
        if (spi_done) begin
          if (!ad_en) begin
            // Enable dropped during the frame: abandon the burst.
            state_d    = ST_IDLE;
            wr_cnt_d   = 5'd0;
            cfg_done_d = 1'b0;
          end else if (wr_cnt_inc == {1'b0, CFG_FRM}) begin
            state_d    = ST_IDLE;
            wr_cnt_d   = CON_CNT;
            cfg_done_d = 1'b1;
          end else begin
            state_d  = ST_CON_GAP;
            wr_cnt_d = wr_cnt_inc;
          end
        end else if (tmo) begin
          state_d = ST_FAULT;
        end
      end

      ST_CON_GAP: begin
        if (!ad_en) begin
          state_d    = ST_IDLE;
          wr_cnt_d   = 5'd0;
          cfg_done_d = 1'b0;
        end else if (tmr_zero) begin
          state_d = ST_CON_RDY;
        end
      end

      ST_CNV_HI: begin
        if (tmr_zero) begin
          state_d = ST_CNV_WAIT;
        end
      end

      ST_CNV_WAIT: begin
        if (ad_rvs) begin
          // wr_cnt must already hold the read index while in RD_RDY.
          state_d  = ST_RD_RDY;
          wr_cnt_d = CON_CNT;
        end else if (tmo) begin
          state_d = ST_FAULT;
        end
      end

      ST_RD_RDY: begin
        state_d = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        if (spi_done) begin
          state_d   = ST_IDLE;
          ad_data_d = spi_rdata[31:16];
          ad_vld_d  = 1'b1;
        end else if (tmo) begin
          state_d = ST_FAULT;
        end
      end

      ST_FAULT: begin
        // Leaving FAULT forces a full reconfiguration on the next enable.
        if (!ad_en) begin
          state_d    = ST_IDLE;
          wr_cnt_d   = 5'd0;
          cfg_done_d = 1'b0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        wr_cnt_d = 5'd0;
      end
    endcase

    // Ticks are never queued: one arriving mid-cycle is only recorded.
    if (prd_tick && (state_q != ST_IDLE)) begin
      smp_ovr_d = 1'b1;
    end
    if (en_rise) begin
      smp_ovr_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q    <= ST_IDLE;
      wr_cnt_q   <= 5'd0;
      convst_q   <= 1'b0;
      ad_data_q  <= 16'h0000;
      ad_vld_q   <= 1'b0;
      cfg_done_q <= 1'b0;
      smp_ovr_q  <= 1'b0;
      ad_en_q    <= 1'b0;
      prd_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      convst_q   <= (state_d == ST_CNV_HI);
      ad_data_q  <= ad_data_d;
      ad_vld_q   <= ad_vld_d;
      cfg_done_q <= cfg_done_d;
      smp_ovr_q  <= smp_ovr_d;
      ad_en_q    <= ad_en;
      prd_q      <= prd_d;
    end
  end

  assign cur_state = state_q;
  assign wr_cnt    = wr_cnt_q;
  assign ad_convst = convst_q;
  assign ad_data   = ad_data_q;
  assign ad_vld    = ad_vld_q;
  assign cfg_done  = cfg_done_q;
  assign smp_ovr   = smp_ovr_q;

endmodule

// File: tb/tb_ads8689_seq.sv
// ----------------------------------------------------------------------------
// tb_ads8689_seq
// Directed bench for ads8689_seq: reset state, configuration burst, sample
// cycle, overrun, abort/re-enable, asynchronous reset in RD_WAIT and (when
// ADS8689_TMO_EN is defined) the watchdog.
// ----------------------------------------------------------------------------
module tb_ads8689_seq;

  // Hand-written expected constants.
  localparam logic [7:0] S_IDLE     = 8'h00;
  localparam logic [7:0] S_CON_RDY  = 8'h01;
  localparam logic [7:0] S_CON_WAIT = 8'h02;
  localparam logic [7:0] S_CON_GAP  = 8'h04;
  localparam logic [7:0] S_CNV_WAIT = 8'h10;
  localparam logic [7:0] S_RD_RDY   = 8'h20;
  localparam logic [7:0] S_RD_WAIT  = 8'h40;
  localparam int         N_CFG      = 8;
  localparam int         N_GAP      = 8;
  localparam int         N_CNV      = 125;
  localparam int         N_PRD      = 1250;

  logic        clk_sys;
  logic        rst_sys_n;
  logic        ad_en;
  logic        spi_done;
  logic [31:0] spi_rdata;
  logic        ad_rvs;
  logic [7:0]  cur_state;
  logic [4:0]  wr_cnt;
  logic        ad_convst;
  logic [15:0] ad_data;
  logic        ad_vld;
  logic        cfg_done;
  logic        smp_ovr;
  logic        ad_fault;

  int n_cmp = 0;
  int n_err = 0;

  ads8689_seq dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .ad_en     (ad_en),
    .spi_done  (spi_done),
    .spi_rdata (spi_rdata),
    .ad_rvs    (ad_rvs),
    .cur_state (cur_state),
    .wr_cnt    (wr_cnt),
    .ad_convst (ad_convst),
    .ad_data   (ad_data),
    .ad_vld    (ad_vld),
    .cfg_done  (cfg_done),
    .smp_ovr   (smp_ovr),
    .ad_fault  (ad_fault)
  );

  initial clk_sys = 1'b0;
  always #4 clk_sys = ~clk_sys;

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation ran past 2 ms, expected completion");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [7:0] st, input int budget,
                            output int n);
    n = 0;
    while (cur_state !== st && n < budget) begin
      tick();
      n++;
    end
    check(tag, cur_state, st);
  endtask

  task automatic pulse_done(input logic [31:0] rdata);
    spi_done  = 1'b1;
    spi_rdata = rdata;
    tick();
    spi_done  = 1'b0;
  endtask

  // Runs frames 0..nfrm-1 of the configuration burst; ad_en already high.
  task automatic run_cfg(input int nfrm);
    int n;
    for (int i = 0; i < nfrm; i++) begin
      wait_state("cfg_rdy", S_CON_RDY, 20, n);
      check("cfg_rdy_lat", n, (i == 0) ? 1 : N_GAP);
      check("cfg_wr_cnt", wr_cnt, i);
      tick();
      check("cfg_wait", cur_state, S_CON_WAIT);
      tick();
      tick();
      check("cfg_wait_hold", cur_state, S_CON_WAIT);
      pulse_done($urandom);
      if (i < N_CFG - 1) begin
        check("cfg_gap", cur_state, S_CON_GAP);
        check("cfg_gap_wr_cnt", wr_cnt, i + 1);
      end else begin
        check("cfg_end_state", cur_state, S_IDLE);
        check("cfg_end_done", cfg_done, 1);
        check("cfg_end_wr_cnt", wr_cnt, 16);
      end
      $display("cfg frame %0d: state=%02h wr_cnt=%0d", i, cur_state, wr_cnt);
    end
  endtask

  task automatic wait_convst(input int budget, output int n);
    n = 0;
    while (ad_convst !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("convst_rise", ad_convst, 1);
  endtask

  // One conversion + read; returns after a quiet window following ad_vld.
  task automatic do_sample(input logic [31:0] rdata, input int rvs_delay, input int exp_lat);
    int n;
    int extra;
    wait_convst(1400, n);
    if (exp_lat > 0) check("convst_lat", n, exp_lat);
    n = 0;
    while (ad_convst === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("convst_len", n, N_CNV);
    check("cnv_wait", cur_state, S_CNV_WAIT);
    repeat (rvs_delay) tick();
    check("cnv_wait_hold", cur_state, S_CNV_WAIT);
    ad_rvs = 1'b1;
    tick();
    check("rd_rdy", cur_state, S_RD_RDY);
    check("rd_wr_cnt", wr_cnt, 16);
    tick();
    ad_rvs = 1'b0;
    check("rd_wait", cur_state, S_RD_WAIT);
    tick();
    pulse_done(rdata);
    check("vld_hi", ad_vld, 1);
    check("ad_data", ad_data, rdata[31:16]);
    check("rd_to_idle", cur_state, S_IDLE);
    $display("sample: ad_data=%04h smp_ovr=%0b", ad_data, smp_ovr);
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ad_vld === 1'b1) extra++;
    end
    check("extra_vld", extra, 0);
    check("post_idle", cur_state, S_IDLE);
    check("post_convst", ad_convst, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},   cur_state, 8'h00);
    check({tag, "_wr_cnt"},  wr_cnt, 0);
    check({tag, "_convst"},  ad_convst, 0);
    check({tag, "_data"},    ad_data, 16'h0000);
    check({tag, "_vld"},     ad_vld, 0);
    check({tag, "_cfgdone"}, cfg_done, 0);
    check({tag, "_ovr"},     smp_ovr, 0);
    check({tag, "_fault"},   ad_fault, 0);
  endtask

  initial begin
    int n;
    rst_sys_n = 1'b0;
    ad_en     = 1'b0;
    spi_done  = 1'b0;
    spi_rdata = 32'h0;
    ad_rvs    = 1'b0;
    repeat (3) tick();
    check_reset_vals("rst");
    rst_sys_n = 1'b1;
    tick();
    check("idle_hold", cur_state, S_IDLE);

    // Configuration burst.
    ad_en = 1'b1;
    run_cfg(N_CFG);

    // First sample: tick one full period after cfg_done.
    do_sample(32'hABCD_0000, 3, N_PRD);
    check("no_ovr", smp_ovr, 0);

    // Overrun: RVS held low past the next tick.
    do_sample(32'h1234_5678, 1300, 0);
    check("ovr_set", smp_ovr, 1);

    // ad_en low in IDLE keeps cfg_done; re-enable clears smp_ovr.
    ad_en = 1'b0;
    tick();
    check("dis_idle", cur_state, S_IDLE);
    check("dis_cfg_kept", cfg_done, 1);
    ad_en = 1'b1;
    tick();
    check("ren_ovr_clr", smp_ovr, 0);
    check("ren_no_cfg", cur_state, S_IDLE);

    // Abort during CON_GAP after frame 3.
    rst_sys_n = 1'b0;
    ad_en     = 1'b0;
    tick();
    rst_sys_n = 1'b1;
    tick();
    ad_en = 1'b1;
    run_cfg(4);
    check("abort_pre", cur_state, S_CON_GAP);
    ad_en = 1'b0;
    tick();
    check("abort_state", cur_state, S_IDLE);
    check("abort_cfg", cfg_done, 0);
    check("abort_wr_cnt", wr_cnt, 0);
    ad_en = 1'b1;
    run_cfg(N_CFG);

    // Asynchronous reset in RD_WAIT.
    wait_convst(1400, n);
    wait_state("to_cnv_wait", S_CNV_WAIT, 200, n);
    ad_rvs = 1'b1;
    tick();
    ad_rvs = 1'b0;
    tick();
    check("ar_rd_wait", cur_state, S_RD_WAIT);
    #2;
    rst_sys_n = 1'b0;
    #1;
    check_reset_vals("arst");
    ad_en = 1'b0;
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
    tick();
    pulse_done(32'hFFFF_FFFF);
    check("late_vld", ad_vld, 0);
    check("late_data", ad_data, 16'h0000);
    check("late_state", cur_state, S_IDLE);

`ifdef ADS8689_TMO_EN
    // Watchdog in CON_WAIT.
    ad_en = 1'b1;
    wait_state("tmo_rdy", S_CON_RDY, 5, n);
    tick();
    check("tmo_wait", cur_state, S_CON_WAIT);
    n = 0;
    while (cur_state !== 8'h80 && n < 5000) begin
      tick();
      n++;
    end
    check("tmo_state", cur_state, 8'h80);
    check("tmo_len", n, 4095);
    check("tmo_fault", ad_fault, 1);
    check("tmo_convst", ad_convst, 0);
    pulse_done(32'h0);
    check("tmo_ign_done", cur_state, 8'h80);
    ad_en = 1'b0;
    tick();
    check("tmo_exit", cur_state, S_IDLE);
    check("tmo_exit_cfg", cfg_done, 0);
    check("tmo_exit_wr", wr_cnt, 0);
    check("tmo_fault_kept", ad_fault, 1);
    ad_en = 1'b1;
    tick();
    check("tmo_reconf", cur_state, S_CON_RDY);
    check("tmo_reconf_wr", wr_cnt, 0);
    check("tmo_fault_clr", ad_fault, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ads8689_seq.md
# ads8689_seq

Sequencer for one ADS8689 analog-input channel. It owns the `cur_state`/`wr_cnt` pair that drives the channel's register-command generator (`ADREG`) and the SPI frame engine. After `ad_en` rises it issues the eight-frame configuration burst, then runs periodic CONVST → read cycles and delivers 16-bit samples to the AI channel logic. It sits inside `ads8689ctl`, between the channel enable/period logic and `ADREG` + SPI master.

## Interface
- `CON_CNT`, 5'd16: `wr_cnt` value that marks a data-read frame (must match `ADREG`).
- `CFG_FRM`, 4'd8: number of configuration frames (`wr_cnt` 0..CFG_FRM-1).
- `CNV_CYC`, 16'd125: CONVST high time in `clk_sys` cycles (1 µs at 125 MHz).
- `GAP_CYC`, 8'd8: idle cycles between consecutive configuration frames.
- `SMP_PRD`, 16'd1250: sample period in cycles (≥ CNV_CYC + read time).
- `TMO_CYC`, 16'd4095: watchdog limit for SPI done / RVS wait.
- `clk_sys` input 1: system clock, 125 MHz.
- `rst_sys_n` input 1: asynchronous, active-low reset.
- `ad_en` input 1: channel enable, level.
- `spi_done` input 1: one-cycle pulse from the SPI engine when the current 32-bit frame completes.
- `spi_rdata` input 32: frame read data, valid with `spi_done`.
- `ad_rvs` input 1: ADS8689 RVS pin, synchronised upstream; high = conversion finished.
- `cur_state` output 8: sequencer state, to `ADREG`.
- `wr_cnt` output 5: frame index, to `ADREG`.
- `ad_convst` output 1: CONVST pin.
- `ad_data` output 16: last sample, `spi_rdata[31:16]`.
- `ad_vld` output 1: one-cycle strobe with new `ad_data`.
- `cfg_done` output 1: configuration burst completed.
- `smp_ovr` output 1: sticky; a period tick arrived while a cycle was in progress.
- `ad_fault` output 1: sticky; watchdog expired.

## Operation
- States, one-hot except IDLE: IDLE 8'h00, CON_RDY 8'h01, CON_WAIT 8'h02, CON_GAP 8'h04, CNV_HI 8'h08, CNV_WAIT 8'h10, RD_RDY 8'h20, RD_WAIT 8'h40, FAULT 8'h80.
- Reset values:
  - `cur_state`=IDLE; `wr_cnt`=0.
  - `ad_convst`, `ad_vld`, `cfg_done`, `smp_ovr`, `ad_fault` = 0.
  - `ad_data`=16'h0000.
  - Period counter = 0.
- IDLE:
  - `ad_en`=1 and `cfg_done`=0 → CON_RDY with `wr_cnt`=0.
  - `ad_en`=1, `cfg_done`=1 and period tick → CNV_HI.
  - Otherwise hold.
- CON_RDY lasts exactly one cycle, then CON_WAIT.
- CON_WAIT: on `spi_done`, `wr_cnt`+1.
  - If new `wr_cnt` = CFG_FRM: `wr_cnt`←CON_CNT, `cfg_done`←1, go to IDLE.
  - Else go to CON_GAP.
- CON_GAP: GAP_CYC cycles, then CON_RDY. `ad_en`=0 here or in CON_WAIT (after done) aborts to IDLE with `cfg_done`=0 and `wr_cnt`=0.
- CNV_HI: `ad_convst`=1 for CNV_CYC cycles, then CNV_WAIT with `ad_convst`=0.
- CNV_WAIT: wait for `ad_rvs`=1, then RD_RDY.
- RD_RDY lasts one cycle with `wr_cnt`=CON_CNT; `ADREG` fires `rd_trig`. Then RD_WAIT.
- RD_WAIT: on `spi_done`, `ad_data`←`spi_rdata[31:16]` and `ad_vld`=1 for one cycle, then IDLE.
- Period counter:
  - Runs freely from 0 to SMP_PRD-1 while `cfg_done`=1 and `ad_en`=1; otherwise held at 0.
  - The tick occurs at wrap.
  - A tick seen outside IDLE sets `smp_ovr` and is dropped. There is no queueing.
- `ad_en` falling during the conversion or read path: the current cycle completes, then IDLE. `cfg_done` is retained.
- FAULT:
  - `ad_fault`=1 and `ad_convst`=0; `spi_done` is ignored.
  - Exit only on `ad_en`=0 → IDLE, clearing `cfg_done` and setting `wr_cnt`=0, which forces reconfiguration.
  - `ad_fault` and `smp_ovr` clear only on reset or on the `ad_en` rising edge.
- `spi_done` outside CON_WAIT/RD_WAIT is ignored.
- Reset asserted mid-frame: everything returns to reset values. The SPI engine is reset by the same `rst_sys_n`.

## Timing
- All outputs are registered.
- `ADREG` registers `wr_trig`/`rd_trig`/`wr_data` one cycle after `cur_state`=CON_RDY/RD_RDY. The SPI engine must see them no earlier than the cycle after, so CON_RDY/RD_RDY are single-cycle and `wr_cnt` is stable throughout.
- `ad_en` rise to `cur_state`=CON_RDY: 1 cycle.
- `spi_done` to next CON_RDY: 1 + GAP_CYC cycles.
- `ad_convst` high exactly CNV_CYC cycles.
- `ad_rvs` high to RD_RDY: 1 cycle.
- `spi_done` in RD_WAIT to `ad_vld`: 1 cycle.

## Configuration
- `ADS8689_TMO_EN` defined:
  - A watchdog counts cycles in CON_WAIT, RD_WAIT and CNV_WAIT.
  - Reaching TMO_CYC → FAULT.
  - The counter clears on every state change.
- Undefined: no watchdog. Those states wait indefinitely, FAULT is unreachable, and `ad_fault` is tied 0.

## Structure
- Package/DEFINES `ads8689_pkg` holds:
  - State encodings (shared with `ADREG`'s CON_RDY/RD_RDY).
  - CON_CNT.
  - The CMD_*/register address constants.
- One natural sub-module, `ads8689_dncnt`: a loadable down-counter with zero flag. It is instantiated for the gap/CONVST timer and for the watchdog.

## Test plan
- Config burst: `ad_en` 0→1 → eight CON_RDY pulses with `wr_cnt` 0..7, each released by `spi_done`. `cfg_done`=1 after the 8th, and `wr_cnt`=16.
- Sample cycle: `SMP_PRD`=1250 tick → `ad_convst` high 125 cycles; `ad_rvs`=1 → RD_RDY. `spi_done` with `spi_rdata`=32'hABCD0000 → `ad_data`=16'hABCD with a single-cycle `ad_vld`.
- Overrun: hold `ad_rvs`=0 past the next tick → `smp_ovr`=1 and that tick is dropped. After release, exactly one `ad_vld` is produced.
- Timeout (`ADS8689_TMO_EN`): no `spi_done` in CON_WAIT for 4095 cycles → FAULT with `ad_fault`=1. `ad_en` 0→1 → reconfiguration from `wr_cnt`=0.
- Abort: `ad_en`=0 during CON_GAP after frame 3 → IDLE with `cfg_done`=0. Re-enable restarts at `wr_cnt`=0.
- Async reset asserted in RD_WAIT → all outputs at reset values immediately, and a late `spi_done` is ignored.
